// File: rtl/key_step_debounce_pkg.sv
// Shared definitions for the key debounce block: FSM state encoding and
// default timing constants derived from the board clock.
package key_pkg;

  localparam int unsigned CLK_HZ            = 50_000_000;
  localparam int unsigned DEBOUNCE_MS       = 20;
  localparam int unsigned DEF_STABLE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

  typedef enum logic [1:0] {
    REL       = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } key_state_e;

endpackage

// File: rtl/key_step_debounce_sync_2ff.sv
// Two-flop synchroniser for asynchronous switch/key inputs; the reset value
// is chosen by the caller so idle levels survive reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic ck,
  input  logic rs,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge ck) begin
    if (rs) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/key_step_debounce.sv
// Debounces an active-low pushbutton into a clean level, press/release pulses
// and a count-step pulse (press plus optional hold-to-repeat ticks).
module key_step_debounce
  import key_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_W         = 24,
  parameter int unsigned REPEAT_EN     = 0,
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic ck,
  input  logic rs,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic step_pulse
);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic key_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .ck (ck),
    .rs (rs),
    .d  (key_n),
    .q  (key_s)
  );

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             pressed_q, pressed_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             step_q, step_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    pressed_d = pressed_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    step_d    = 1'b0;
    unique case (state_q)
      REL: begin
        pressed_d = 1'b0;
        phase_d   = 1'b0;
        if (!key_s) begin
          state_d = PRESS_CHK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      PRESS_CHK: begin
        if (key_s) begin
          state_d = REL;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d   = HELD;
          cnt_d     = '0;
          phase_d   = 1'b0;
          pressed_d = 1'b1;
          press_d   = 1'b1;
          step_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        pressed_d = 1'b1;
        if (key_s) begin
          state_d = REL_CHK;
          cnt_d   = CNT_ONE;
          phase_d = 1'b0;
        end else if (REPEAT_EN != 0) begin
          // phase 0 waits the initial delay, phase 1 free-runs at the period
          if ((!phase_q && cnt_q == DELAY_LAST) || (phase_q && cnt_q == PERIOD_LAST)) begin
            step_d  = 1'b1;
            cnt_d   = '0;
            phase_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      REL_CHK: begin
        if (!key_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d   = REL;
          cnt_d     = '0;
          pressed_d = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = REL;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge ck) begin
    if (rs) begin
      state_q   <= REL;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
      step_q    <= step_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign step_pulse    = step_q;

endmodule
